wb_write_buffer: RTL and testbench
==================================

# wb_write_buffer

Write-side initiator for `register_file`: a 4-entry in-order queue that accepts register writebacks from execute/load units through a valid/ready handshake and drains them, one per cycle, into the register file's `we`/`wa`/`wd` port. Writes to x0 are discarded at entry. An optional forwarding lookup lets the decode stage see pending, not-yet-committed values. It sits between the writeback mux and `register_file`.

## Interface
- `DEPTH`, 4: number of queue entries; must be a power of two, at least 2.
- `XLEN`, 32: data width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  writeback request present.
- `in_ready`  out  1  queue can accept; equals `count != DEPTH`.
- `in_addr`  in  5  destination register.
- `in_data`  in  XLEN  write data.
- `rf_stall`  in  1  register-file write port unavailable this cycle.
- `rf_we`  out  1  write strobe to `register_file.we`.
- `rf_wa`  out  5  write address to `register_file.wa`.
- `rf_wd`  out  XLEN  write data to `register_file.wd`.
- `fwd_ra1`, `fwd_ra2`  in  5  lookup addresses, mirroring the register-file read ports.
- `fwd_hit1`, `fwd_hit2`  out  1  the lookup matched a pending entry.
- `fwd_data1`, `fwd_data2`  out  XLEN  data from the youngest matching entry.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `empty`  out  1  `count == 0`; used by fences and halt logic.

## Operation
- **Accept.** A push happens when `in_valid && in_ready` at a rising edge.
  - If `in_addr == 0`, the handshake completes but nothing is enqueued and `count` is unchanged.
- **Drain.**
  - `rf_we = !empty && !rf_stall`.
  - `rf_wa` and `rf_wd` always show the head entry. They show 0 when empty.
  - The head is popped at every edge where `rf_we` is 1.
- **Ordering.**
  - Entries leave strictly in FIFO order.
  - Duplicate destinations are kept as separate entries.
- **Pointers.** Read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. `count` is tracked separately so full and empty are unambiguous.
- **Simultaneous push and pop.** `count` is unchanged and both pointers advance.
- **Full.** When `count == DEPTH`, `in_ready` is 0 even if a pop happens in the same cycle. There is no same-cycle pass-through.
- **Forwarding.** A lookup scans the valid entries combinationally.
  - `fwd_hitN` is 1 if any valid entry has address equal to `fwd_raN`, and `fwd_raN != 0`.
  - `fwd_dataN` is the data of the youngest match, and 0 when there is no hit.
  - An entry being popped in the current cycle still counts as a hit.
  - The request currently on `in_*` is not searched.

## Timing
- **Reset values** (applied immediately, asynchronously): `count` = 0, `empty` = 1, `in_ready` = 1, `rf_we` = 0, `rf_wa` = 0, `rf_wd` = 0, `fwd_hit*` = 0, `fwd_data*` = 0. Both pointers return to 0.
- **Reset during operation** discards all pending entries. No partial write is issued.
- **Latency, empty queue:**
  - Request accepted at edge N.
  - `rf_we` is high during cycle N+1.
  - The register file is updated at edge N+2.
- **Throughput:** one push and one pop per cycle.
- **`rf_stall`** holds the head entry and `rf_we` low for as long as it is asserted. No entry is lost.

## Configuration
- Macro: `WB_BYPASS_EN`.
- **Defined:** the forwarding lookup is built as described under Operation.
- **Undefined:**
  - The match logic is not built.
  - `fwd_hit*` and `fwd_data*` are tied to 0.
  - The ports remain, so parent connections do not change.

## Structure
- **Shared package `wb_pkg`:**
  - `wb_entry_t` packed struct holding `addr[4:0]` and `data[XLEN-1:0]`.
  - `WB_DEPTH_DEFAULT = 4`.
  - `REG_ZERO = 5'd0`.
- **Sub-module `wb_fwd_match`:**
  - Takes the entry array, the valid mask, the head pointer and one lookup address.
  - Returns a hit flag and data, using a youngest-first priority search.
  - Instantiated twice, only under `WB_BYPASS_EN`.

## Test plan
1. **Reset:** assert reset mid-cycle with 2 entries pending -> `count` = 0, `rf_we` = 0 and `in_ready` = 1 without waiting for a clock edge.
2. **Single write:** push x1 = 0x1111_2222 -> `rf_we` = 1, `rf_wa` = 1, `rf_wd` = 0x1111_2222 for exactly one cycle. A following read of `register_file` x1 returns 0x1111_2222.
3. **x0 discard:** push x0 = 0xDEAD_BEEF -> handshake completes, `count` stays 0, `rf_we` never asserts, x0 reads 0.
4. **Fill and wrap:**
   - Hold `rf_stall` = 1 and push x1..x4 -> `count` = 4, `in_ready` = 0.
   - Release the stall -> writes x1, x2, x3, x4 in order on consecutive cycles.
   - Repeat 3 times to exercise pointer wrap.
5. **Forwarding** (`WB_BYPASS_EN`):
   - With the stall held, push x5 = 0xA and then x5 = 0xB; set `fwd_ra1` = 5 -> `fwd_hit1` = 1, `fwd_data1` = 0xB.
   - Set `fwd_ra2` = 0 -> `fwd_hit2` = 0.
6. **Concurrent push and pop** at `count` = 2, with no stall -> `count` remains 2 and the register file ends with the last value written to each address.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write buffer.
package wb_pkg;
  localparam int WB_XLEN          = 32;
  localparam int WB_DEPTH_DEFAULT = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]         addr;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Combinational lookup of one address across the pending entries; youngest match wins.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  wb_entry_t [DEPTH-1:0]         entries_i,
  input  logic      [DEPTH-1:0]         vld_i,
  input  logic      [$clog2(DEPTH)-1:0] head_i,
  input  logic      [4:0]               ra_i,
  output logic                          hit_o,
  output logic      [WB_XLEN-1:0]       data_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest so the last match assigned is the youngest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (vld_i[idx] && (entries_i[idx].addr == ra_i) && (ra_i != REG_ZERO)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_write_buffer.sv
// In-order writeback queue draining one entry per cycle into register_file (accept->we: 1 cycle),
// in_ready drops only when full; rf_stall holds the head. Forwarding lookup built under WB_BYPASS_EN.
module wb_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  parameter int XLEN  = WB_XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     rf_stall,
  output logic                     rf_we,
  output logic [4:0]               rf_wa,
  output logic [XLEN-1:0]          rf_wd,
  input  logic [4:0]               fwd_ra1,
  input  logic [4:0]               fwd_ra2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data1,
  output logic [XLEN-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  wb_entry_t [DEPTH-1:0]  entries_q;
  wb_entry_t              head;
  logic                   push, pop;

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = (count_q != CW'(DEPTH));
  assign head     = entries_q[rd_ptr_q];

  // x0 writes complete the handshake but never occupy a slot.
  assign push = in_valid && in_ready && (in_addr != REG_ZERO);
  assign pop  = rf_we;

  assign rf_we = !empty && !rf_stall;
  assign rf_wa = empty ? 5'd0 : head.addr;
  assign rf_wd = empty ? '0   : head.data;

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      entries_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        entries_q[wr_ptr_q] <= '{addr: in_addr, data: in_data};
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    age;

  // Slot i is live when its distance from the head is below the occupancy.
  always_comb begin
    vld = '0;
    age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age    = PW'(i) - rd_ptr_q;
      vld[i] = (CW'(age) < count_q);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_match1 (
    .entries_i (entries_q),
    .vld_i     (vld),
    .head_i    (rd_ptr_q),
    .ra_i      (fwd_ra1),
    .hit_o     (fwd_hit1),
    .data_o    (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_match2 (
    .entries_i (entries_q),
    .vld_i     (vld),
    .head_i    (rd_ptr_q),
    .ra_i      (fwd_ra2),
    .hit_o     (fwd_hit2),
    .data_o    (fwd_data2)
  );
`else
  logic unused_fwd_ra;
  assign unused_fwd_ra = ^{fwd_ra1, fwd_ra2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer: directed table, corner sequences, randomized run vs queue model.
module tb_wb_write_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [4:0]        in_addr;
  logic [XLEN-1:0]   in_data;
  logic              rf_stall, rf_we;
  logic [4:0]        rf_wa;
  logic [XLEN-1:0]   rf_wd;
  logic [4:0]        fwd_ra1, fwd_ra2;
  logic              fwd_hit1, fwd_hit2;
  logic [XLEN-1:0]   fwd_data1, fwd_data2;
  logic [2:0]        count;
  logic              empty;

  always #5 clk = ~clk;

  wb_write_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd_ra1(fwd_ra1), .fwd_ra2(fwd_ra2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count), .empty(empty)
  );

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] rf_exp [32];
  logic [31:0] rf_obs [32];
  int n_chk  = 0;
  int n_fail = 0;

  // Stand-in for register_file: captures whatever the DUT writes.
  always @(posedge clk) begin
    if (!reset && rf_we) rf_obs[rf_wa] <= rf_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [4:0] ra, output bit h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (BYP && ra != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == ra) begin
          h = 1'b1;
          d = q[i].d;
          break;
        end
      end
    end
  endfunction

  task automatic check_model();
    int sz = q.size();
    bit h;
    logic [31:0] d;
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    chk("rf_we", 32'(rf_we), 32'(sz != 0 && !rf_stall));
    chk("rf_wa", 32'(rf_wa), sz != 0 ? 32'(q[0].a) : 32'd0);
    chk("rf_wd", rf_wd, sz != 0 ? q[0].d : 32'd0);
    lookup(fwd_ra1, h, d);
    chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
    chk("fwd_data1", fwd_data1, d);
    lookup(fwd_ra2, h, d);
    chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
    chk("fwd_data2", fwd_data2, d);
  endtask

  // Effect of the coming rising edge on the model.
  task automatic model_edge();
    bit do_pop  = (q.size() != 0) && !rf_stall;
    bit do_push = in_valid && (q.size() != DEPTH) && (in_addr != 5'd0);
    ent_t e;
    if (do_pop) begin
      rf_exp[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (do_push) begin
      e.a = in_addr;
      e.d = in_data;
      q.push_back(e);
    end
  endtask

  task automatic cyc(input bit v, input logic [4:0] a, input logic [31:0] d, input bit st,
                     input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    in_valid = v; in_addr = a; in_data = d; rf_stall = st; fwd_ra1 = r1; fwd_ra2 = r2;
    #1;
    check_model();
    model_edge();
  endtask

  typedef struct {
    bit v; logic [4:0] a; logic [31:0] d; bit st; logic [4:0] r1;
    int e_cnt; bit e_we; logic [4:0] e_wa; logic [31:0] e_wd; bit e_hit; logic [31:0] e_fd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    for (int i = 0; i < 32; i++) begin rf_exp[i] = '0; rf_obs[i] = '0; end
    in_valid = 0; in_addr = 0; in_data = 0; rf_stall = 0; fwd_ra1 = 0; fwd_ra2 = 0;
    reset = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_wa", 32'(rf_wa), 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_fwd_hit1", 32'(fwd_hit1), 0);
    chk("rst_fwd_data1", fwd_data1, 0);
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b0;

    // single write, forward of an entry being popped, x0 discard, stalled double push to x5
    tbl[0]  = '{1, 5'd1, 32'h1111_2222, 0, 5'd0, 0, 0, 5'd0, 32'h0, 0, 32'h0};
    tbl[1]  = '{0, 5'd0, 32'h0,         0, 5'd1, 1, 1, 5'd1, 32'h1111_2222, BYP, BYP ? 32'h1111_2222 : 32'h0};
    tbl[2]  = '{0, 5'd0, 32'h0,         0, 5'd1, 0, 0, 5'd0, 32'h0, 0, 32'h0};
    tbl[3]  = '{1, 5'd0, 32'hDEAD_BEEF, 0, 5'd0, 0, 0, 5'd0, 32'h0, 0, 32'h0};
    tbl[4]  = '{0, 5'd0, 32'h0,         0, 5'd0, 0, 0, 5'd0, 32'h0, 0, 32'h0};
    tbl[5]  = '{1, 5'd5, 32'hA,         1, 5'd5, 0, 0, 5'd0, 32'h0, 0, 32'h0};
    tbl[6]  = '{1, 5'd5, 32'hB,         1, 5'd5, 1, 0, 5'd5, 32'hA, BYP, BYP ? 32'hA : 32'h0};
    tbl[7]  = '{0, 5'd0, 32'h0,         1, 5'd5, 2, 0, 5'd5, 32'hA, BYP, BYP ? 32'hB : 32'h0};
    tbl[8]  = '{0, 5'd0, 32'h0,         0, 5'd5, 2, 1, 5'd5, 32'hA, BYP, BYP ? 32'hB : 32'h0};
    tbl[9]  = '{0, 5'd0, 32'h0,         0, 5'd5, 1, 1, 5'd5, 32'hB, BYP, BYP ? 32'hB : 32'h0};
    tbl[10] = '{0, 5'd0, 32'h0,         0, 5'd5, 0, 0, 5'd0, 32'h0, 0, 32'h0};

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].r1, 5'd0);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_we", i), 32'(rf_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_wa", i), 32'(rf_wa), 32'(tbl[i].e_wa));
      chk($sformatf("tbl%0d_wd", i), rf_wd, tbl[i].e_wd);
      chk($sformatf("tbl%0d_hit1", i), 32'(fwd_hit1), 32'(tbl[i].e_hit));
      chk($sformatf("tbl%0d_fd1", i), fwd_data1, tbl[i].e_fd);
      chk($sformatf("tbl%0d_hit2", i), 32'(fwd_hit2), 0);
    end
    chk("x1_committed", rf_obs[1], 32'h1111_2222);
    chk("x0_reads_zero", rf_obs[0], 32'h0);
    chk("x5_last_value", rf_obs[5], 32'hB);

    // fill under stall, refuse when full, drain in order; repeated to wrap pointers
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 1; k <= 4; k++) cyc(1, 5'(k), 32'(rep * 16 + k), 1, 5'd0, 5'd0);
      cyc(1, 5'd7, 32'h77, 1, 5'd0, 5'd0);
      chk("full_count", 32'(count), 4);
      chk("full_in_ready", 32'(in_ready), 0);
      for (int k = 1; k <= 4; k++) begin
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
        chk("drain_we", 32'(rf_we), 1);
        chk("drain_order", 32'(rf_wa), 32'(k));
      end
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
      chk("drained_empty", 32'(empty), 1);
    end
    chk("x7_never_written", rf_obs[7], 32'h0);

    // concurrent push and pop at count 2
    cyc(1, 5'd8, 32'h800, 1, 5'd0, 5'd0);
    cyc(1, 5'd9, 32'h900, 1, 5'd0, 5'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, (i % 2) ? 5'd9 : 5'd8, 32'h1000 + 32'(i), 0, 5'd8, 5'd9);
      chk("pushpop_count", 32'(count), 2);
    end
    for (int i = 0; i < 3; i++) cyc(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    chk("pushpop_x8", rf_obs[8], 32'h1004);
    chk("pushpop_x9", rf_obs[9], 32'h1005);

    // asynchronous reset with two entries pending
    cyc(1, 5'd10, 32'hAAAA, 1, 5'd10, 5'd0);
    cyc(1, 5'd11, 32'hBBBB, 1, 5'd10, 5'd0);
    @(negedge clk);
    in_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_rf_we", 32'(rf_we), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_fwd_hit1", 32'(fwd_hit1), 0);
    q.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    cyc(0, 5'd0, 32'h0, 0, 5'd10, 5'd11);
    chk("x10_not_written", rf_obs[10], 32'h0);

    // randomized traffic against the queue model
    for (int i = 0; i < 2000; i++) begin
      cyc(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom(),
          1'($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 6; i++) cyc(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), rf_obs[i], rf_exp[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
